core_control: RTL and testbench



---
 rtl/core_control_pkg.sv | 60 ++++++
 rtl/core_control.sv | 125 ++++++++++++
 tb/tb_core_control.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_control_pkg.sv
// core_control_pkg: shared types and opcode constants for the RV32I multi-cycle control FSM
package core_control_pkg;

    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        U_TYPE,
        J_TYPE,
        INVALID_TYPE
    } inst_format_e;

    typedef enum logic [3:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        DECODE,
        EXECUTE,
        MEM_REQ,
        MEM_WAIT,
        WRITEBACK,
        TRAP
    } ctrl_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_IMM,
        PC_ALU
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_LOAD,
        WB_PC4
    } wb_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_ILLEGAL,
        CAUSE_IMEM_TIMEOUT,
        CAUSE_DMEM_TIMEOUT
    } trap_cause_e;

    function automatic logic opcode_legal(input logic [6:0] opc);
        return opc inside {OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI,
                           OPC_AUIPC, OPC_BRANCH, OPC_JAL, OPC_JALR};
    endfunction

endpackage

// File: rtl/core_control.sv
// core_control: multi-cycle RV32I control FSM with retire counter and sticky trap
module core_control
    import core_control_pkg::*;
#(
    parameter int INSTRET_WIDTH = 32,
    parameter int MEM_TIMEOUT   = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  inst_format_e             format_i,
    input  logic [6:0]               opcode_i,
    input  logic                     branch_taken_i,
    output logic                     imem_req_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    input  logic                     dmem_gnt_i,
    input  logic                     dmem_rvalid_i,
    output logic                     ir_we_o,
    output logic                     pc_we_o,
    output logic [1:0]               pc_sel_o,
    output logic                     alu_a_sel_o,
    output logic                     alu_b_sel_o,
    output logic                     rf_we_o,
    output logic [1:0]               wb_sel_o,
    output logic                     trap_o,
    output logic [1:0]               trap_cause_o,
    output logic [INSTRET_WIDTH-1:0] instret_o
);

    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;

    ctrl_state_e              state_q, state_d;
    trap_cause_e              cause_q, cause_d;
    logic [6:0]               opc_q;
    logic [CW-1:0]            cnt_q;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic                     timeout, mem_phase, phase_entry, in_exec, store_done;
    logic                     is_load, is_store, is_op, is_branch, is_jal, is_jalr, is_auipc;

    assign is_load   = opc_q == OPC_LOAD;
    assign is_store  = opc_q == OPC_STORE;
    assign is_op     = opc_q == OPC_OP;
    assign is_branch = opc_q == OPC_BRANCH;
    assign is_jal    = opc_q == OPC_JAL;
    assign is_jalr   = opc_q == OPC_JALR;
    assign is_auipc  = opc_q == OPC_AUIPC;

    assign mem_phase   = state_q inside {FETCH_REQ, FETCH_WAIT, MEM_REQ, MEM_WAIT};
    assign phase_entry = (state_d == FETCH_REQ && state_q != FETCH_REQ) ||
                         (state_d == MEM_REQ && state_q != MEM_REQ);
    // Trips on the last allowed cycle of a phase unless that cycle completes it.
    assign timeout     = (MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT - 1));
    assign cause_d     = state_q == DECODE ? CAUSE_ILLEGAL :
                         state_q inside {FETCH_REQ, FETCH_WAIT} ? CAUSE_IMEM_TIMEOUT :
                         CAUSE_DMEM_TIMEOUT;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            opc_q     <= '0;
            cause_q   <= CAUSE_NONE;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            if (state_q == DECODE) opc_q <= opcode_i;
            if (state_d == TRAP && state_q != TRAP) cause_q <= cause_d;
            cnt_q <= phase_entry ? '0 : mem_phase ? cnt_q + CW'(1) : cnt_q;
            if (pc_we_o) instret_q <= instret_q + INSTRET_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = FETCH_REQ;
            FETCH_REQ:  state_d = imem_gnt_i ? (imem_rvalid_i ? DECODE : FETCH_WAIT) :
                                  timeout ? TRAP : FETCH_REQ;
            FETCH_WAIT: state_d = imem_rvalid_i ? DECODE : timeout ? TRAP : FETCH_WAIT;
            DECODE:     state_d = (format_i == INVALID_TYPE || !opcode_legal(opcode_i)) ?
                                  TRAP : EXECUTE;
            EXECUTE:    state_d = (is_load || is_store) ? MEM_REQ :
                                  is_branch ? FETCH_REQ : WRITEBACK;
            MEM_REQ:    state_d = dmem_gnt_i ? (!dmem_rvalid_i ? MEM_WAIT :
                                  is_load ? WRITEBACK : FETCH_REQ) :
                                  timeout ? TRAP : MEM_REQ;
            MEM_WAIT:   state_d = dmem_rvalid_i ? (is_load ? WRITEBACK : FETCH_REQ) :
                                  timeout ? TRAP : MEM_WAIT;
            WRITEBACK:  state_d = FETCH_REQ;
            default:    state_d = state_q;
        endcase
    end

    // ALU selects stay valid through the memory and writeback steps so the
    // address, link and jump target computed by the ALU remain stable.
    assign in_exec    = state_q inside {EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK};
    assign store_done = is_store && ((state_q == MEM_REQ && dmem_gnt_i && dmem_rvalid_i) ||
                                     (state_q == MEM_WAIT && dmem_rvalid_i));

    always_comb begin
        imem_req_o   = state_q == FETCH_REQ;
        ir_we_o      = (state_q == FETCH_REQ && imem_gnt_i && imem_rvalid_i) ||
                       (state_q == FETCH_WAIT && imem_rvalid_i);
        dmem_req_o   = state_q == MEM_REQ;
        dmem_we_o    = state_q == MEM_REQ && is_store;
        alu_a_sel_o  = in_exec && (is_auipc || is_jal);
        alu_b_sel_o  = in_exec && !(is_op || is_branch);
        rf_we_o      = state_q == WRITEBACK;
        pc_we_o      = state_q == WRITEBACK || (state_q == EXECUTE && is_branch) || store_done;
        pc_sel_o     = (state_q == EXECUTE && is_branch && branch_taken_i) ? PC_IMM :
                       (state_q == WRITEBACK && is_jal) ? PC_IMM :
                       (state_q == WRITEBACK && is_jalr) ? PC_ALU : PC_PLUS4;
        wb_sel_o     = state_q != WRITEBACK ? WB_ALU : is_load ? WB_LOAD :
                       (is_jal || is_jalr) ? WB_PC4 : WB_ALU;
        trap_o       = state_q == TRAP;
        trap_cause_o = cause_q;
        instret_o    = instret_q;
    end

endmodule

// File: tb/tb_core_control.sv
// tb_core_control: directed cycle-exact checks of the core_control FSM
module tb_core_control;
    import core_control_pkg::*;

    localparam logic [14:0] IMR  = 15'h4000, DMR = 15'h2000, DWE = 15'h1000, IRW = 15'h0800;
    localparam logic [14:0] PCW  = 15'h0400, PCS1 = 15'h0100, PCS2 = 15'h0200;
    localparam logic [14:0] ASEL = 15'h0080, BSEL = 15'h0040, RFW = 15'h0020;
    localparam logic [14:0] WB1  = 15'h0008, WB2 = 15'h0010, TRP = 15'h0004;
    localparam logic [14:0] TC1  = 15'h0001, TC2 = 15'h0002, TC3 = 15'h0003;

    logic         clk = 0, rst;
    inst_format_e fmt;
    logic [6:0]   opc;
    logic         taken, imem_req, imem_gnt, imem_rvalid, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic         ir_we, pc_we, alu_a, alu_b, rf_we, trap;
    logic [1:0]   pc_sel, wb_sel, trap_cause;
    logic [31:0]  instret;
    logic [14:0]  outs;
    int           total = 0, bad = 0;

    core_control #(.INSTRET_WIDTH(32), .MEM_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst), .format_i(fmt), .opcode_i(opc), .branch_taken_i(taken),
        .imem_req_o(imem_req), .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_gnt_i(dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid), .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_sel_o(pc_sel),
        .alu_a_sel_o(alu_a), .alu_b_sel_o(alu_b), .rf_we_o(rf_we), .wb_sel_o(wb_sel),
        .trap_o(trap), .trap_cause_o(trap_cause), .instret_o(instret)
    );

    assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a, alu_b,
                   rf_we, wb_sel, trap, trap_cause};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] v);
        {imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid, taken} = v;
    endtask

    task automatic load(input logic [31:0] w, input inst_format_e f);
        opc = w[6:0];
        fmt = f;
    endtask

    task automatic do_reset;
        set_in(5'b0);
        rst = 1;
        tick;
        rst = 0;
        tick;
    endtask

    task automatic test_reset;
        rst = 1;
        set_in(5'b11111);
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (outs !== 15'h0 || instret !== 32'd0) begin
                bad++;
                $display("FAIL reset cyc%0d outs=%h instret=%0d exp outs=0 instret=0", i, outs, instret);
            end
        end
        rst = 0;
        set_in(5'b0);
        #1;
        total++;
        if (outs !== 15'h0) begin
            bad++;
            $display("FAIL reset_release outs=%h exp=0", outs);
        end
        tick;
        total++;
        if (outs !== IMR || instret !== 32'd0) begin
            bad++;
            $display("FAIL reset_first_fetch outs=%h instret=%0d exp outs=%h instret=0", outs, instret, IMR);
        end
    endtask

    task automatic test_add;
        logic [4:0]  si [4] = '{5'b11000, 5'b00010, 5'b00000, 5'b00000};
        logic [14:0] se [4] = '{IMR | IRW, 15'h0, 15'h0, RFW | PCW};
        load(32'h002081B3, R_TYPE);
        for (int i = 0; i < 4; i++) begin
            set_in(si[i]);
            #1;
            total++;
            if (outs !== se[i]) begin
                bad++;
                $display("FAIL add cyc%0d outs=%h exp=%h", i, outs, se[i]);
            end
            tick;
        end
        set_in(5'b0);
        total++;
        if (instret !== 32'd1) begin
            bad++;
            $display("FAIL add_instret got=%0d exp=1", instret);
        end
    endtask

    task automatic test_load;
        logic [4:0]  si [8] = '{5'b11000, 5'b00000, 5'b00000, 5'b00000,
                                5'b00000, 5'b00100, 5'b00010, 5'b00000};
        logic [14:0] se [8] = '{IMR | IRW, 15'h0, BSEL, DMR | BSEL, DMR | BSEL, DMR | BSEL,
                                BSEL, RFW | PCW | WB1 | BSEL};
        load(32'h0040A183, I_TYPE);
        for (int i = 0; i < 8; i++) begin
            set_in(si[i]);
            #1;
            total++;
            if (outs !== se[i]) begin
                bad++;
                $display("FAIL lw cyc%0d outs=%h exp=%h", i, outs, se[i]);
            end
            tick;
        end
        set_in(5'b0);
        total++;
        if (instret !== 32'd2) begin
            bad++;
            $display("FAIL lw_instret got=%0d exp=2", instret);
        end
    endtask

    task automatic test_branch;
        logic [4:0]  si [6] = '{5'b11000, 5'b00000, 5'b00001, 5'b11000, 5'b00001, 5'b00000};
        logic [14:0] se [6] = '{IMR | IRW, 15'h0, PCW | PCS1, IMR | IRW, 15'h0, PCW};
        load(32'h00208463, B_TYPE);
        for (int i = 0; i < 6; i++) begin
            set_in(si[i]);
            #1;
            total++;
            if (outs !== se[i]) begin
                bad++;
                $display("FAIL beq cyc%0d outs=%h exp=%h", i, outs, se[i]);
            end
            tick;
        end
        set_in(5'b0);
        total++;
        if (instret !== 32'd4) begin
            bad++;
            $display("FAIL beq_instret got=%0d exp=4", instret);
        end
    endtask

    task automatic test_jumps;
        logic [4:0]  si [9] = '{5'b10000, 5'b01000, 5'b00000, 5'b00000, 5'b00000,
                                5'b11000, 5'b00000, 5'b00000, 5'b00000};
        logic [14:0] se [9] = '{IMR, IRW, 15'h0, ASEL | BSEL,
                                RFW | PCW | PCS1 | WB2 | ASEL | BSEL,
                                IMR | IRW, 15'h0, BSEL, RFW | PCW | PCS2 | WB2 | BSEL};
        for (int i = 0; i < 9; i++) begin
            if (i == 0) load(32'h010000EF, J_TYPE);
            if (i == 5) load(32'h000080E7, I_TYPE);
            set_in(si[i]);
            #1;
            total++;
            if (outs !== se[i]) begin
                bad++;
                $display("FAIL jal_jalr cyc%0d outs=%h exp=%h", i, outs, se[i]);
            end
            tick;
        end
        set_in(5'b0);
        total++;
        if (instret !== 32'd6) begin
            bad++;
            $display("FAIL jump_instret got=%0d exp=6", instret);
        end
    endtask

    task automatic test_store;
        logic [4:0]  si [4] = '{5'b11000, 5'b00000, 5'b00000, 5'b00110};
        logic [14:0] se [4] = '{IMR | IRW, 15'h0, BSEL, DMR | DWE | PCW | BSEL};
        load(32'h0020A423, S_TYPE);
        for (int i = 0; i < 4; i++) begin
            set_in(si[i]);
            #1;
            total++;
            if (outs !== se[i]) begin
                bad++;
                $display("FAIL sw cyc%0d outs=%h exp=%h", i, outs, se[i]);
            end
            tick;
        end
        set_in(5'b0);
        #1;
        total++;
        if (outs !== IMR || instret !== 32'd7) begin
            bad++;
            $display("FAIL sw_after outs=%h instret=%0d exp outs=%h instret=7", outs, instret, IMR);
        end
    endtask

    task automatic test_illegal;
        logic [4:0]  si [3] = '{5'b11000, 5'b00000, 5'b00000};
        logic [14:0] se [3] = '{IMR | IRW, 15'h0, TRP | TC1};
        load(32'h00000073, I_TYPE);
        for (int i = 0; i < 2; i++) begin
            set_in(si[i]);
            #1;
            total++;
            if (outs !== se[i]) begin
                bad++;
                $display("FAIL sys cyc%0d outs=%h exp=%h", i, outs, se[i]);
            end
            tick;
        end
        set_in(5'b11111);
        for (int i = 0; i < 50; i++) begin
            #1;
            total++;
            if (outs !== (TRP | TC1) || instret !== 32'd7) begin
                bad++;
                $display("FAIL trap_hold cyc%0d outs=%h instret=%0d exp outs=%h instret=7",
                         i, outs, instret, TRP | TC1);
            end
            tick;
        end
        rst = 1;
        tick;
        total++;
        if (outs !== 15'h0 || instret !== 32'd0) begin
            bad++;
            $display("FAIL trap_reset outs=%h instret=%0d exp outs=0 instret=0", outs, instret);
        end
        rst = 0;
        set_in(5'b0);
        tick;
        load({25'h0, OPC_OP}, INVALID_TYPE);
        for (int i = 0; i < 3; i++) begin
            set_in(si[i]);
            #1;
            total++;
            if (outs !== se[i]) begin
                bad++;
                $display("FAIL invalid_fmt cyc%0d outs=%h exp=%h", i, outs, se[i]);
            end
            tick;
        end
        do_reset;
    endtask

    task automatic test_timeout;
        logic [4:0]  si [8] = '{5'b11000, 5'b00000, 5'b00000, 5'b00001,
                                5'b10001, 5'b01001, 5'b00001, 5'b00000};
        logic [14:0] se [8] = '{IMR | IRW, 15'h0, BSEL, DMR | DWE | BSEL, DMR | DWE | BSEL,
                                DMR | DWE | BSEL, DMR | DWE | BSEL, TRP | TC3};
        load(32'h0020A423, S_TYPE);
        for (int i = 0; i < 8; i++) begin
            set_in(si[i]);
            #1;
            total++;
            if (outs !== se[i]) begin
                bad++;
                $display("FAIL dmem_timeout cyc%0d outs=%h exp=%h", i, outs, se[i]);
            end
            tick;
        end
        do_reset;
        imem_gnt = 1;
        tick;
        rst = 1;
        imem_gnt = 0;
        imem_rvalid = 1;
        tick;
        rst = 0;
        #1;
        total++;
        if (outs !== 15'h0) begin
            bad++;
            $display("FAIL reset_mid_fetch outs=%h exp=0", outs);
        end
        tick;
        for (int i = 0; i < 5; i++) begin
            set_in(i == 0 ? 5'b01110 : 5'b00110);
            #1;
            total++;
            if (outs !== (i < 4 ? IMR : (TRP | TC2)) || instret !== 32'd0) begin
                bad++;
                $display("FAIL imem_timeout cyc%0d outs=%h instret=%0d exp outs=%h instret=0",
                         i, outs, instret, i < 4 ? IMR : (TRP | TC2));
            end
            tick;
        end
        set_in(5'b0);
    endtask

    initial begin
        fmt = R_TYPE;
        opc = '0;
        set_in(5'b0);
        test_reset;
        test_add;
        test_load;
        test_branch;
        test_jumps;
        test_store;
        test_illegal;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
